// File: rtl/injector_param.sv
// injector_param: synthetic traffic injector for one mesh node.
// Picks a destination by traffic pattern, waits an LFSR-driven gap, then
// issues a registered request/packet and holds it until the downstream grant.
module injector_param #(
    parameter int          MESH_X   = 5,
    parameter int          MESH_Y   = 5,
    parameter int          X_POS    = 1,
    parameter int          Y_POS    = 1,
    parameter int          DIM      = 4,
    parameter int          PID_W    = 10,
    parameter logic [5:0]  ModuleID = 6'b000_000,
    parameter logic [3:0]  GAP_MASK = 4'hF,
    parameter logic [15:0] SEED     = 16'hACE1,
    parameter int          MAX_PKTS = 1023,
    parameter int          HOT_X    = 0,
    parameter int          HOT_Y    = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      Enable,
    input  logic [1:0]                Mode,
    input  logic                      DnStrFull,
    input  logic                      GntDnStr,
    output logic                      ReqDnStr,
    output logic [4*DIM+PID_W+5:0]    PacketOut,
    output logic                      Done,
    output logic [PID_W-1:0]          SentCount
);

    typedef enum logic [2:0] {
        IDLE, PKT_PREP, GAP, SEND_REQ, WAIT_GRANT, DONE
    } state_t;

    // Own coordinates as the source fields carry them (sign bit is always 0).
    localparam logic [DIM-2:0] XP = (DIM-1)'(X_POS);
    localparam logic [DIM-2:0] YP = (DIM-1)'(Y_POS);

    state_t      state;
    logic [15:0] lfsr;
    logic [3:0]  gap;
    logic [2:0]  dst_x, dst_y;

    logic [2:0]  cand_x, cand_y;
    logic        cand_self, cand_in_mesh;
    logic [DIM-1:0] x_field, y_field;
    logic [4*DIM+PID_W+5:0] pkt_next;

    // Magnitude of a signed offset, truncated to the coordinate field.
    function automatic logic [DIM-2:0] mag(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return a[DIM-2:0];
    endfunction

    // Free-running Galois LFSR, x^16+x^14+x^13+x^11+1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) lfsr <= SEED;
        else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    end

    // Destination candidate for the current mode and its legality.
    always_comb begin
        cand_x = 3'(HOT_X);
        cand_y = 3'(HOT_Y);
        case (Mode)
            2'd0: begin cand_x = lfsr[6:4];              cand_y = lfsr[10:8]; end
            2'd1: begin cand_x = 3'(Y_POS);              cand_y = 3'(X_POS); end
            2'd2: begin cand_x = 3'(MESH_X - 1 - X_POS); cand_y = 3'(MESH_Y - 1 - Y_POS); end
            default: ;
        endcase
        cand_self    = (cand_x == 3'(X_POS)) && (cand_y == 3'(Y_POS));
        cand_in_mesh = (int'(cand_x) < MESH_X) && (int'(cand_y) < MESH_Y);
    end

    // Offset encoding of the latched destination: east positive on x, north
    // (negative dy) flagged on y; a zero offset yields an all-zero field.
    always_comb begin
        int dx, dy;
        dx = int'(dst_x) - X_POS;
        dy = int'(dst_y) - Y_POS;
        x_field  = {(dx > 0), mag(dx)};
        y_field  = {(dy < 0), mag(dy)};
        pkt_next = {x_field, y_field, 1'b0, XP, 1'b0, YP,
                    SentCount + PID_W'(1), ModuleID};
    end

    // Injection FSM with registered request, packet, done and grant count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            ReqDnStr  <= 1'b0;
            PacketOut <= '0;
            Done      <= 1'b0;
            SentCount <= '0;
            gap       <= '0;
            dst_x     <= '0;
            dst_y     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (int'(SentCount) >= MAX_PKTS) begin
                        state <= DONE;
                        Done  <= 1'b1;
                    end else if (Enable) begin
                        state <= PKT_PREP;
                    end
                end
                PKT_PREP: begin
                    if (Mode == 2'd0) begin
                        // Random mode keeps resampling until it hits a legal node.
                        if (cand_in_mesh && !cand_self) begin
                            dst_x <= cand_x;
                            dst_y <= cand_y;
                            gap   <= lfsr[3:0] & GAP_MASK;
                            state <= GAP;
                        end
                    end else if (cand_self) begin
                        // Deterministic pattern maps onto ourselves: nothing to send.
                        state <= DONE;
                        Done  <= 1'b1;
                    end else begin
                        dst_x <= cand_x;
                        dst_y <= cand_y;
                        gap   <= lfsr[3:0] & GAP_MASK;
                        state <= GAP;
                    end
                end
                GAP: begin
                    if (gap == 4'd0) state <= SEND_REQ;
                    else             gap   <= gap - 4'd1;
                end
                SEND_REQ: begin
                    if (!DnStrFull) begin
                        ReqDnStr  <= 1'b1;
                        PacketOut <= pkt_next;
                        state     <= WAIT_GRANT;
                    end
                end
                WAIT_GRANT: begin
                    if (GntDnStr) begin
                        ReqDnStr  <= 1'b0;
                        SentCount <= SentCount + PID_W'(1);
                        state     <= IDLE;
                    end
                end
                DONE: begin
                    Done     <= 1'b1;
                    ReqDnStr <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_injector_param.sv
// Bench for injector_param: directed scenarios on a hotspot instance with
// zero gap, and randomized multi-packet runs on a budget-limited instance
// checked against a schedule computed from the LFSR sequence.
module tb_injector_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Instance A: hotspot (4,3), no gap, default budget.
    logic        rst_a = 1'b0, en_a = 1'b0, full_a = 1'b0, gnt_a = 1'b0;
    logic [1:0]  mode_a = 2'd0;
    logic        req_a, done_a;
    logic [31:0] pkt_a;
    logic [9:0]  cnt_a;

    // Instance B: full gap mask, budget of three packets.
    logic        rst_b = 1'b0, en_b = 1'b0, full_b = 1'b0, gnt_b = 1'b0;
    logic [1:0]  mode_b = 2'd0;
    logic        req_b, done_b;
    logic [31:0] pkt_b;
    logic [9:0]  cnt_b;

    injector_param #(.HOT_X(4), .HOT_Y(3), .GAP_MASK(4'h0)) u_dir (
        .clk(clk), .reset(rst_a), .Enable(en_a), .Mode(mode_a),
        .DnStrFull(full_a), .GntDnStr(gnt_a), .ReqDnStr(req_a),
        .PacketOut(pkt_a), .Done(done_a), .SentCount(cnt_a));

    injector_param #(.MAX_PKTS(3)) u_rnd (
        .clk(clk), .reset(rst_b), .Enable(en_b), .Mode(mode_b),
        .DnStrFull(full_b), .GntDnStr(gnt_b), .ReqDnStr(req_b),
        .PacketOut(pkt_b), .Done(done_b), .SentCount(cnt_b));

    logic [15:0] lf_tab [0:4095];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Packet from node (1,1) to (x,y), ModuleID 0.
    function automatic logic [31:0] pkt_of(input int x, input int y, input int pid);
        int dx, dy, xf, yf;
        dx = x - 1;
        dy = y - 1;
        xf = (dx > 0 ? 8 : 0) + (dx < 0 ? -dx : dx);
        yf = (dy < 0 ? 8 : 0) + (dy < 0 ? -dy : dy);
        return 32'((xf << 28) | (yf << 24) | (1 << 20) | (1 << 16) | (pid << 6));
    endfunction

    function automatic bit dst_ok(input logic [15:0] l);
        int x, y;
        x = int'(l[6:4]);
        y = int'(l[10:8]);
        return (x < 5) && (y < 5) && !(x == 1 && y == 1);
    endfunction

    initial begin
        lf_tab[0] = 16'hACE1;
        for (int i = 1; i < 4096; i++)
            lf_tab[i] = {1'b0, lf_tab[i-1][15:1]} ^ (lf_tab[i-1][0] ? 16'hB400 : 16'h0000);

        repeat (2) @(negedge clk);
        chk("rst_req", {31'b0, req_a}, 0);
        chk("rst_pkt", pkt_a, 0);
        chk("rst_done", {31'b0, done_a}, 0);
        chk("rst_cnt", {22'b0, cnt_a}, 0);

        // Hotspot: request on the 4th edge, then grant delayed 5 cycles.
        en_a = 1'b1; mode_a = 2'd3; rst_a = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick;
            chk("hot_req", {31'b0, req_a}, (i == 4) ? 1 : 0);
        end
        chk("hot_pkt", pkt_a, 32'hB2110040);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("hold_req", {31'b0, req_a}, 1);
            chk("hold_pkt", pkt_a, 32'hB2110040);
            chk("hold_cnt", {22'b0, cnt_a}, 0);
        end
        gnt_a = 1'b1;
        tick;
        gnt_a = 1'b0; en_a = 1'b0;
        chk("gnt_req", {31'b0, req_a}, 0);
        chk("gnt_cnt", {22'b0, cnt_a}, 1);
        for (int i = 0; i < 6; i++) begin
            tick;
            chk("disabled_req", {31'b0, req_a}, 0);
            chk("disabled_cnt", {22'b0, cnt_a}, 1);
        end

        // Reset while waiting for grant clears everything before the next edge.
        en_a = 1'b1;
        for (int i = 0; i < 20 && !req_a; i++) tick;
        chk("req_seen", {31'b0, req_a}, 1);
        chk("second_pid", pkt_a, 32'hB2110080);
        #2 rst_a = 1'b0;
        #1;
        chk("arst_req", {31'b0, req_a}, 0);
        chk("arst_pkt", pkt_a, 0);
        chk("arst_cnt", {22'b0, cnt_a}, 0);
        chk("arst_done", {31'b0, done_a}, 0);

        // Bit-complement destination (3,3).
        @(negedge clk);
        mode_a = 2'd2; rst_a = 1'b1;
        repeat (4) tick;
        chk("bc_req", {31'b0, req_a}, 1);
        chk("bc_pkt", pkt_a, 32'hA2110040);

        // Downstream full for 10 SEND_REQ cycles; Enable dropped mid-flight.
        rst_a = 1'b0;
        @(negedge clk);
        mode_a = 2'd3; full_a = 1'b1; en_a = 1'b1; rst_a = 1'b1;
        for (int i = 1; i <= 13; i++) begin
            tick;
            chk("full_req", {31'b0, req_a}, 0);
            if (i == 5) en_a = 1'b0;
            if (i == 13) full_a = 1'b0;
        end
        tick;
        chk("full_release_req", {31'b0, req_a}, 1);
        chk("full_release_pkt", pkt_a, 32'hB2110040);
        rst_a = 1'b0;

        // Randomized runs on the budget-limited instance.
        for (int run = 0; run < 24; run++) begin
            int m, n, k, t, c, g, s0, done_from, x, y, guard;
            bit f, gr, stop;
            logic [31:0] ep;
            rst_b = 1'b0; en_b = 1'b0;
            @(negedge clk);
            m = (run < 4) ? run : int'($urandom_range(0, 3));
            mode_b = 2'(m);
            en_b = 1'b1;
            full_b = 1'($urandom_range(0, 1));
            gnt_b  = 1'($urandom_range(0, 1));
            rst_b = 1'b1;
            n = 0; k = 0; t = 0; done_from = 0; stop = 0;
            while (!stop) begin
                if (k == 3) begin
                    done_from = t + 1;
                    stop = 1;
                end else begin
                    c = t + 1;
                    case (m)
                        0: begin
                            while (c < 4000 && !dst_ok(lf_tab[c])) c++;
                            x = int'(lf_tab[c][6:4]);
                            y = int'(lf_tab[c][10:8]);
                        end
                        1: begin x = 1; y = 1; end
                        2: begin x = 3; y = 3; end
                        default: begin x = 0; y = 0; end
                    endcase
                    if (x == 1 && y == 1) begin
                        done_from = c + 1;
                        stop = 1;
                    end else begin
                        g  = int'(lf_tab[c][3:0]);
                        s0 = c + g + 2;
                        ep = pkt_of(x, y, k + 1);
                        while (n < s0) begin
                            chk("pre_req", {31'b0, req_b}, 0);
                            chk("pre_cnt", {22'b0, cnt_b}, 32'(k));
                            chk("pre_done", {31'b0, done_b}, 0);
                            full_b = 1'($urandom_range(0, 1));
                            gnt_b  = 1'($urandom_range(0, 1));
                            tick; n++;
                        end
                        guard = 0;
                        do begin
                            chk("send_req", {31'b0, req_b}, 0);
                            chk("send_cnt", {22'b0, cnt_b}, 32'(k));
                            f = (guard >= 20) ? 1'b0 : 1'($urandom_range(0, 1));
                            full_b = f;
                            gnt_b  = 1'($urandom_range(0, 1));
                            tick; n++; guard++;
                        end while (f);
                        guard = 0;
                        do begin
                            chk("wait_req", {31'b0, req_b}, 1);
                            chk("wait_pkt", pkt_b, ep);
                            chk("wait_cnt", {22'b0, cnt_b}, 32'(k));
                            chk("wait_done", {31'b0, done_b}, 0);
                            gr = (guard >= 20) ? 1'b1 : ($urandom_range(0, 2) == 0);
                            gnt_b  = gr;
                            full_b = 1'($urandom_range(0, 1));
                            tick; n++; guard++;
                        end while (!gr);
                        k++;
                        t = n;
                    end
                end
            end
            while (n < done_from) begin
                chk("end_req", {31'b0, req_b}, 0);
                chk("end_done", {31'b0, done_b}, 0);
                tick; n++;
            end
            for (int i = 0; i < 4; i++) begin
                chk("done_flag", {31'b0, done_b}, 1);
                chk("done_req", {31'b0, req_b}, 0);
                chk("done_cnt", {22'b0, cnt_b}, 32'(k));
                gnt_b = 1'($urandom_range(0, 1));
                tick;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/injector_param.md
INJECTOR_PARAM -- requirements
Module: injector_param

Interface
REQ-001 The block SHALL have parameter MESH_X, default 5, meaning mesh columns (2..8).
REQ-002 The block SHALL have parameter MESH_Y, default 5, meaning mesh rows (2..8).
REQ-003 The block SHALL have parameters X_POS, default 1, and Y_POS, default 1, meaning own node coordinates.
REQ-004 The block SHALL have parameter DIM, default 4, meaning bits per coordinate field (1 sign + DIM-1 magnitude).
REQ-005 The block SHALL have parameter PID_W, default 10, meaning PacketID width.
REQ-006 The block SHALL have parameter ModuleID, default 6'b000_000, meaning 6-bit sender tag.
REQ-007 The block SHALL have parameters GAP_MASK, default 4'hF, meaning inter-packet gap mask, and SEED, default 16'hACE1, meaning nonzero LFSR seed.
REQ-008 The block SHALL have parameters MAX_PKTS, default 1023, meaning packet budget (<2^PID_W), and HOT_X/HOT_Y, default 0/0, meaning hotspot node.
REQ-009 The block SHALL have clk  input  1  single clock, all flops rising edge.
REQ-010 The block SHALL have reset  input  1  asynchronous, active-low.
REQ-011 The block SHALL have Enable  input  1  generation permitted when high.
REQ-012 The block SHALL have Mode  input  2  0 uniform random, 1 transpose, 2 bit-complement, 3 hotspot.
REQ-013 The block SHALL have DnStrFull  input  1  downstream buffer full.
REQ-014 The block SHALL have GntDnStr  input  1  downstream grant.
REQ-015 The block SHALL have ReqDnStr  output  1  request, registered.
REQ-016 The block SHALL have PacketOut  output  4*DIM+PID_W+6  {xDst,yDst,xSrc,ySrc,PacketID,ModuleID}, registered.
REQ-017 The block SHALL have Done  output  1  budget exhausted or no legal destination.
REQ-018 The block SHALL have SentCount  output  PID_W  granted packets.

Function
REQ-019 States SHALL be IDLE, PKT_PREP, GAP, SEND_REQ, WAIT_GRANT, DONE.
REQ-020 IDLE SHALL go to PKT_PREP when Enable=1 and SentCount<MAX_PKTS; to DONE when SentCount==MAX_PKTS; else stay.
REQ-021 A 16-bit Galois LFSR (taps x^16+x^14+x^13+x^11+1) SHALL advance every cycle out of reset; no $random.
REQ-022 PKT_PREP SHALL load gap counter with LFSR[3:0]&GAP_MASK and pick destination: mode 0 x=LFSR[6:4], y=LFSR[10:8]; mode 1 (Y_POS,X_POS); mode 2 (MESH_X-1-X_POS, MESH_Y-1-Y_POS); mode 3 (HOT_X,HOT_Y).
REQ-023 Mode 0 SHALL stay in PKT_PREP, resampling each cycle, while x>=MESH_X, y>=MESH_Y, or destination equals own node.
REQ-024 Modes 1-3 with destination equal to own node SHALL go to DONE with no request.
REQ-025 xDst SHALL be {dx>0, |dx|}, dx=dst_x-X_POS; yDst SHALL be {dy<0, |dy|}, dy=dst_y-Y_POS (north=1); zero offset encodes all-zero.
REQ-026 xSrc/ySrc SHALL be {1'b0,X_POS}/{1'b0,Y_POS}; PacketID SHALL be SentCount+1 truncated to PID_W.
REQ-027 GAP SHALL decrement to zero then enter SEND_REQ; gap 0 spends one cycle in GAP.
REQ-028 SEND_REQ with DnStrFull=0 SHALL set ReqDnStr=1, load PacketOut, enter WAIT_GRANT in the same edge; DnStrFull=1 SHALL hold in SEND_REQ.
REQ-029 WAIT_GRANT SHALL hold ReqDnStr=1 and PacketOut stable until GntDnStr sampled 1, then clear ReqDnStr, increment SentCount, enter IDLE.
REQ-030 GntDnStr outside WAIT_GRANT SHALL be ignored.
REQ-031 Enable deassert SHALL only be honoured in IDLE; an in-flight packet completes.
REQ-032 DONE SHALL be terminal until reset, Done=1, ReqDnStr=0.

Reset
REQ-033 reset=0 SHALL immediately force IDLE, ReqDnStr=0, PacketOut=0, Done=0, SentCount=0, gap=0, LFSR=SEED, including mid-WAIT_GRANT.

Verification
REQ-034 Reset asserted during WAIT_GRANT -> ReqDnStr, PacketOut, SentCount, Done all 0 before next clk edge.
REQ-035 Mode 3, HOT=(4,3), GAP_MASK=0, Enable=1 -> ReqDnStr=1 on the 4th edge; PacketOut=32'hB2110040.
REQ-036 Mode 2, 5x5, GAP_MASK=0 -> dst (3,3): xDst=4'b1_010, yDst=4'b0_010.
REQ-037 DnStrFull=1 for 10 cycles in SEND_REQ -> ReqDnStr=0 throughout; rises on the edge after release.
REQ-038 GntDnStr delayed 5 cycles -> ReqDnStr held 6 cycles, PacketOut unchanged, SentCount+1 once.
REQ-039 MAX_PKTS=3, mode 0 -> exactly 3 grants, PacketIDs 1,2,3, no self destination, then Done=1 permanently.
